// File: rtl/sys_reset_ctrl.sv
// System reset sequencer: debounced pushbutton, HOLD -> FLASH_RST -> FLASH_WAIT -> RUN.
// Optional software reset request port enabled by defining SYS_RESET_SWREQ_EN.
module sys_reset_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int HOLD_CYCLES       = 256,
    parameter int FLASH_RST_CYCLES  = 64,
    parameter int FLASH_WAIT_CYCLES = 128
) (
    input  logic       io_clock,
    input  logic       io_reset_n,
    input  logic       io_button_n,
`ifdef SYS_RESET_SWREQ_EN
    input  logic       io_swReset_req,
`endif
    output logic       io_flash_rst_n,
    output logic       io_sys_reset,
    output logic       io_ready,
    output logic [1:0] io_cause,
    output logic [1:0] o_dbg_state
);

    localparam int MAX_AB = (HOLD_CYCLES > FLASH_RST_CYCLES) ? HOLD_CYCLES : FLASH_RST_CYCLES;
    localparam int MAX_P  = (MAX_AB > FLASH_WAIT_CYCLES) ? MAX_AB : FLASH_WAIT_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;
    localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] FRST_LD  = CW'(FLASH_RST_CYCLES - 1);
    localparam logic [CW-1:0] FWAIT_LD = CW'(FLASH_WAIT_CYCLES - 1);
    localparam logic [DW-1:0] DEB_HIT  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_SAT  = DW'(DEBOUNCE_CYCLES);

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_SW     = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD       = 2'd0,
        ST_FLASH_RST  = 2'd1,
        ST_FLASH_WAIT = 2'd2,
        ST_RUN        = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [CW-1:0]   w_rem;
    logic [CW-1:0]   w_rem_dec;
    logic            r_fresh;
    logic            r_btn_meta;
    logic            r_btn_sync;
    logic [DW-1:0]   r_deb_cnt;
    logic            w_press;
    logic            w_sw_req;
    logic [1:0]      r_cause;
    logic [1:0]      w_cause_nx;
    logic            r_sys_reset;
    logic            r_flash_rst_n;
    logic            r_ready;

`ifdef SYS_RESET_SWREQ_EN
    assign w_sw_req = io_swReset_req;
`else
    assign w_sw_req = 1'b0;
`endif

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            r_btn_meta <= 1'b1;
            r_btn_sync <= 1'b1;
        end else begin
            r_btn_meta <= io_button_n;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Counter holds the number of consecutive low samples seen before this cycle;
    // saturating one past the hit value makes the press fire once per hold.
    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            r_deb_cnt <= '0;
        end else if (r_btn_sync) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != DEB_SAT) begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
        end
    end

    assign w_press = !r_btn_sync && (r_deb_cnt == DEB_HIT);

    // The cycle right after reset release already counts as the first HOLD cycle,
    // so the cleared counter is read as a freshly reloaded one.
    assign w_rem     = r_fresh ? HOLD_LD : r_cnt;
    assign w_rem_dec = (w_rem == '0) ? '0 : (w_rem - CW'(1));

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = w_rem_dec;
        w_cause_nx = r_cause;
        case (r_state)
            ST_HOLD: begin
                if (!r_btn_sync) begin
                    w_cnt_nx = HOLD_LD;
                end else if (w_rem == '0) begin
                    w_state_nx = ST_FLASH_RST;
                    w_cnt_nx   = FRST_LD;
                end
            end
            ST_FLASH_RST: begin
                if (w_rem == '0) begin
                    w_state_nx = ST_FLASH_WAIT;
                    w_cnt_nx   = FWAIT_LD;
                end
            end
            ST_FLASH_WAIT: begin
                if (w_rem == '0) begin
                    w_state_nx = ST_RUN;
                    w_cnt_nx   = '0;
                end
            end
            ST_RUN: begin
                w_cnt_nx = '0;
                if (w_sw_req) begin
                    w_state_nx = ST_HOLD;
                    w_cnt_nx   = HOLD_LD;
                    w_cause_nx = CAUSE_SW;
                end
            end
            default: begin
                w_state_nx = ST_HOLD;
                w_cnt_nx   = HOLD_LD;
            end
        endcase
        // Button press overrides everything, including a simultaneous software request.
        if (w_press) begin
            w_state_nx = ST_HOLD;
            w_cnt_nx   = HOLD_LD;
            w_cause_nx = CAUSE_BUTTON;
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            r_state       <= ST_HOLD;
            r_cnt         <= '0;
            r_fresh       <= 1'b1;
            r_cause       <= CAUSE_POR;
            r_sys_reset   <= 1'b1;
            r_flash_rst_n <= 1'b1;
            r_ready       <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_fresh       <= 1'b0;
            r_cause       <= w_cause_nx;
            r_sys_reset   <= (w_state_nx != ST_RUN);
            r_flash_rst_n <= (w_state_nx != ST_FLASH_RST);
            r_ready       <= (w_state_nx == ST_RUN);
        end
    end

    assign io_sys_reset   = r_sys_reset;
    assign io_flash_rst_n = r_flash_rst_n;
    assign io_ready       = r_ready;
    assign io_cause       = r_cause;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Bench for sys_reset_ctrl: per-cycle expected outputs queued ahead, compared at negedge.
module tb_sys_reset_ctrl;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int FRST  = 3;
    localparam int FWAIT = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_n = 1'b1;
`ifdef SYS_RESET_SWREQ_EN
    logic       sw_req = 1'b0;
`endif
    logic       flash_n;
    logic       sys_rst;
    logic       ready;
    logic [1:0] cause;
    logic [1:0] dbg_state;

    // Entry layout: {sys_reset, flash_rst_n, ready, cause[1:0]}
    logic [4:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    sys_reset_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .HOLD_CYCLES      (HOLD),
        .FLASH_RST_CYCLES (FRST),
        .FLASH_WAIT_CYCLES(FWAIT)
    ) dut (
        .io_clock      (clk),
        .io_reset_n    (rst_n),
        .io_button_n   (btn_n),
`ifdef SYS_RESET_SWREQ_EN
        .io_swReset_req(sw_req),
`endif
        .io_flash_rst_n(flash_n),
        .io_sys_reset  (sys_rst),
        .io_ready      (ready),
        .io_cause      (cause),
        .o_dbg_state   (dbg_state)
    );

    task automatic push_n(input logic [4:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // n_hold HOLD samples, then flash reset, flash wait and n_run RUN samples.
    task automatic push_seq(input logic [1:0] c, input int n_hold, input int n_run);
        push_n({3'b110, c}, n_hold);
        push_n({3'b100, c}, FRST);
        push_n({3'b110, c}, FWAIT);
        push_n({3'b011, c}, n_run);
    endtask

    task automatic test_reset();
        logic [4:0] got;
        logic [4:0] exp_v;
        int c;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({sys_rst, flash_n, ready, cause} !== 5'b11000 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_values: got %b st=%0d, want 11000 st=0", {sys_rst, flash_n, ready, cause}, dbg_state);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(5'b11000);
        push_seq(2'b00, HOLD - 1, 3);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got   = {sys_rst, flash_n, ready, cause};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL power_on_seq edge %0d: got %b want %b", c, got, exp_v);
            end
            c++;
        end
        n_vec++;
        if (dbg_state !== 2'd3) begin
            n_err++;
            $display("FAIL run_state: got %0d want 3", dbg_state);
        end
    endtask

    // Button low for l_cycles; pre_cause is the cause before the press.
    task automatic test_button(input int l_cycles, input logic [1:0] pre_cause);
        logic [4:0] got;
        logic [4:0] exp_v;
        int c;
        if (l_cycles >= DEB) begin
            push_n({3'b011, pre_cause}, DEB + 1);
            push_seq(2'b01, l_cycles + HOLD - DEB, 3);
        end else begin
            push_n({3'b011, pre_cause}, l_cycles + 10);
        end
        @(posedge clk);
        #1 btn_n = 1'b0;
        c = 1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1 if (c == l_cycles) btn_n = 1'b1;
            @(negedge clk);
            got   = {sys_rst, flash_n, ready, cause};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL button_%0d edge %0d: got %b want %b", l_cycles, c, got, exp_v);
            end
            c++;
        end
    endtask

    task automatic test_reset_mid_flash();
        logic [4:0] got;
        logic [4:0] exp_v;
        int c;
        push_n(5'b01101, DEB + 1);
        push_n(5'b11001, 2 + HOLD);
        push_n(5'b10001, 1);
        @(posedge clk);
        #1 btn_n = 1'b0;
        c = 1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1 if (c == DEB + 2) btn_n = 1'b1;
            @(negedge clk);
            got   = {sys_rst, flash_n, ready, cause};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL pre_abort edge %0d: got %b want %b", c, got, exp_v);
            end
            c++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({sys_rst, flash_n, ready, cause} !== 5'b11000) begin
            n_err++;
            $display("FAIL async_abort: got %b want 11000", {sys_rst, flash_n, ready, cause});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(5'b11000);
        push_seq(2'b00, HOLD - 1, 3);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got   = {sys_rst, flash_n, ready, cause};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL restart_seq edge %0d: got %b want %b", c, got, exp_v);
            end
            c++;
        end
    endtask

`ifdef SYS_RESET_SWREQ_EN
    task automatic test_sw_req();
        logic [4:0] got;
        logic [4:0] exp_v;
        int c;
        push_seq(2'b10, HOLD, 3);
        @(posedge clk);
        #1 sw_req = 1'b1;
        c = 1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1 sw_req = (c == HOLD + FRST + 1);
            @(negedge clk);
            got   = {sys_rst, flash_n, ready, cause};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL sw_req edge %0d: got %b want %b", c, got, exp_v);
            end
            c++;
        end
        sw_req = 1'b0;
    endtask

    task automatic test_button_and_sw();
        logic [4:0] got;
        logic [4:0] exp_v;
        int c;
        push_n(5'b01110, DEB + 1);
        push_seq(2'b01, 2 + HOLD, 3);
        @(posedge clk);
        #1 btn_n = 1'b0;
        c = 1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            if (c == DEB + 2) btn_n = 1'b1;
            sw_req = (c == DEB + 1);
            @(negedge clk);
            got   = {sys_rst, flash_n, ready, cause};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL button_and_sw edge %0d: got %b want %b", c, got, exp_v);
            end
            c++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_button(DEB - 1, 2'b00);
        test_button(10, 2'b00);
        test_reset_mid_flash();
`ifdef SYS_RESET_SWREQ_EN
        test_sw_req();
        test_button_and_sw();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
